// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and checksum helpers for the program loader
package prog_loader_pkg;

    localparam int CSUM_W = 8;
    localparam int ST_W   = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CSUM = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // A program is good when its byte sum plus the trailing checksum is zero mod 2^CSUM_W.
    function automatic logic csum_ok(input logic [CSUM_W-1:0] sum,
                                     input logic [CSUM_W-1:0] c);
        logic [CSUM_W-1:0] total;
        total = sum + c;
        return (total == '0);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream load port and core fetch port of the program loader
interface prog_loader_if #(
    parameter int N = 2
);
    logic         load_req;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic [N-1:0] fetch_addr;
    logic [7:0]   instruction;
    logic         core_hold;
    logic         loaded;
    logic         error;

    modport master (
        output load_req, byte_in, byte_valid, fetch_addr,
        input  byte_ready, instruction, core_hold, loaded, error
    );

    modport slave (
        input  load_req, byte_in, byte_valid, fetch_addr,
        output byte_ready, instruction, core_hold, loaded, error
    );
endinterface

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - 2^N x 8 instruction store, synchronous write, asynchronous read and clear
module prog_ram #(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_we,
    input  logic [N-1:0] i_waddr,
    input  logic [7:0]   i_wdata,
    input  logic [N-1:0] i_raddr,
    output logic [7:0]   o_rdata
);
    localparam int DEPTH = 1 << N;

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot sequencer: streams a program into prog_ram, verifies its checksum, releases the core
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);
    localparam logic [N-1:0] WPTR_LAST = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N-1:0]        r_wptr;
    logic [N-1:0]        w_wptr_nxt;
    logic [CSUM_W-1:0]   r_sum;
    logic [CSUM_W-1:0]   w_sum_nxt;
    logic [CSUM_W-1:0]   w_sum_add;
    logic                w_we;

    assign w_sum_add = r_sum + bus.byte_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_wptr  <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wptr  <= w_wptr_nxt;
            r_sum   <= w_sum_nxt;
        end
    end

    // Outputs depend on r_state only; in LOAD/CSUM ready is 1, so byte_valid alone marks a transfer.
    always_comb begin
        w_state_nxt    = r_state;
        w_wptr_nxt     = r_wptr;
        w_sum_nxt      = r_sum;
        w_we           = 1'b0;
        bus.byte_ready = 1'b0;
        bus.core_hold  = 1'b1;
        bus.loaded     = 1'b0;
        bus.error      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.load_req) begin
                    w_state_nxt = ST_LOAD;
                    w_wptr_nxt  = '0;
                    w_sum_nxt   = '0;
                end
            end
            ST_LOAD: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    w_we       = 1'b1;
                    w_sum_nxt  = w_sum_add;
                    w_wptr_nxt = r_wptr + N'(1);
                    if (r_wptr == WPTR_LAST) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    w_state_nxt = csum_ok(r_sum, bus.byte_in) ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN: begin
                bus.core_hold = 1'b0;
                bus.loaded    = 1'b1;
                if (bus.load_req) begin
                    w_state_nxt = ST_LOAD;
                    w_wptr_nxt  = '0;
                    w_sum_nxt   = '0;
                end
            end
            ST_ERR: begin
                bus.error = 1'b1;
                if (bus.load_req) begin
                    w_state_nxt = ST_LOAD;
                    w_wptr_nxt  = '0;
                    w_sum_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    prog_ram #(.N(N)) u_ram (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (bus.byte_in),
        .i_raddr (bus.fetch_addr),
        .o_rdata (bus.instruction)
    );

endmodule

// File: doc/prog_loader.md
# prog_loader

Writable program store and boot sequencer that replaces the fixed program ROM in front of the 1-bit processor core. It accepts a program as a byte stream over a valid/ready handshake, writes it into a 2^N x 8 instruction memory and checks a trailing checksum. It then releases the core. The core's program counter drives `fetch_addr` and consumes `instruction` exactly as it did from the ROM.

## Interface
- `N`, default 2: program address width. Memory depth is 2^N instructions.

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_req`  in  1  request to (re)load the program. Sampled at the rising edge.
- `byte_in`  in  8  program/checksum byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts `byte_in` this cycle. A transfer occurs when `byte_valid & byte_ready`.
- `fetch_addr`  in  N  core program counter.
- `instruction`  out  8  mem[`fetch_addr`], combinational read. [7:4] is the opcode to the ICU; [3:0] is the select/address field.
- `core_hold`  out  1  high means the core must be held in reset.
- `loaded`  out  1  a program passed its checksum and the core is running.
- `error`  out  1  the last load failed its checksum.

## Operation
- States: IDLE, LOAD, CSUM, RUN, ERR.
- Reset (`rst`=0, asynchronous):
  - state = IDLE, write pointer `wptr` = 0, `sum` = 0.
  - All memory words = 0x00.
  - Outputs: `byte_ready`=0, `core_hold`=1, `loaded`=0, `error`=0.
- IDLE:
  - `core_hold`=1.
  - `load_req`=1 → LOAD with `wptr`=0 and `sum`=0.
- LOAD:
  - `byte_ready`=1, `core_hold`=1.
  - Each transfer writes mem[`wptr`] = `byte_in`, then `sum` = (`sum` + `byte_in`) mod 256 and `wptr`++.
  - The transfer at `wptr` = 2^N-1 → CSUM. The pointer never wraps inside LOAD.
- CSUM:
  - `byte_ready`=1.
  - The next transfer is the checksum byte C and is not written to memory.
  - If (`sum` + C) mod 256 == 0 → RUN, otherwise → ERR.
- RUN: `core_hold`=0, `loaded`=1, `byte_ready`=0. `load_req`=1 → LOAD. `loaded` clears and `core_hold` sets on that same edge.
- ERR: `core_hold`=1, `error`=1, `byte_ready`=0. `load_req`=1 → LOAD and `error` clears.
- `load_req` is ignored in LOAD and CSUM. No restart occurs mid-load.
- `byte_valid` is ignored in IDLE, RUN and ERR. No write occurs and the state does not change.
- Memory keeps the previous program across a failed load. Words already overwritten stay overwritten. The core stays held, so this is harmless.

## Timing
- All outputs except `instruction` are Moore outputs, decoded from the state register only. `byte_ready` has no combinational path from `byte_valid`.
- A write is visible on `instruction` the cycle after its transfer edge.
- Minimum load time is 2^N + 1 transfer cycles. The cycle after the checksum transfer shows RUN, `core_hold`=0 and `loaded`=1.
- The core sees `core_hold` fall at the same edge `loaded` rises. Its program counter starts at 0 on the following edge.
- A `rst` assertion mid-load aborts the load immediately: state IDLE, memory zeroed, `core_hold`=1.

## Structure
- Shared package:
  - state encoding constants (3-bit: IDLE, LOAD, CSUM, RUN, ERR).
  - checksum width (8).
- Sub-module `prog_ram`: 2^N x 8, synchronous write (`we`, `waddr`, `wdata`), asynchronous read, asynchronous active-low clear to 0x00.
- `prog_loader` holds the FSM, `wptr` and `sum`, and instantiates `prog_ram`.

## Test plan
- Reset, then read all `fetch_addr` 0..3 → `instruction` = 0x00 everywhere; `core_hold`=1, `loaded`=0, `byte_ready`=0.
- N=2: pulse `load_req`, then send 0x12, 0x34, 0x56, 0x78, 0xEC back-to-back with `byte_valid` held high → RUN after 5 transfers; `loaded`=1, `core_hold`=0; `instruction` at addresses 0..3 = 0x12, 0x34, 0x56, 0x78.
- Same program with checksum 0xED → `error`=1, `core_hold`=1, `loaded`=0. Then reload with the correct checksum → `error` clears on the `load_req` edge and the load ends in RUN.
- Load with `byte_valid` toggling 1,0,0,1,... → only cycles with valid&ready write; the final memory image matches the stream; `wptr` never skips.
- `rst` low after 2 of 4 bytes → IDLE asynchronously, all words 0x00. `byte_valid` in IDLE is not accepted.
- While in RUN, drive `byte_valid`=1 with 0xFF → no memory change; `load_req` then reloads and `core_hold` rises the same edge.
